// File: rtl/param_offset_accumulator.sv
// Multi-channel accumulator: each accepted transaction adds in_data + OFFSET to the
// selected channel and presents the new value on a registered valid/ready output.
module param_offset_accumulator #(
  parameter int WIDTH    = 32,
  parameter int OFFSET   = 2,
  parameter int CHANNELS = 4,
  parameter int SATURATE = 0,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CH_W-1:0]  in_ch,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CH_W-1:0]  out_ch,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovf
);

  localparam logic [CH_W:0]    CH_LIMIT   = (CH_W + 1)'(CHANNELS);
  localparam logic [WIDTH+1:0] OFFSET_EXT = (WIDTH + 2)'(OFFSET);

  // Returns {overflow, result}; two guard bits hold the carry of both additions.
  function automatic logic [WIDTH:0] add_offset(input logic [WIDTH-1:0] base,
                                                input logic [WIDTH-1:0] data);
    logic [WIDTH+1:0] s;
    logic [WIDTH:0]   r;
    s = {2'b00, base} + {2'b00, data} + OFFSET_EXT;
    if (s[WIDTH+1:WIDTH] == 2'b00) begin
      r = {1'b0, s[WIDTH-1:0]};
    end else if (SATURATE != 0) begin
      r = {1'b1, {WIDTH{1'b1}}};
    end else begin
      r = {1'b1, s[WIDTH-1:0]};
    end
    return r;
  endfunction

  logic [WIDTH-1:0] acc_r [CHANNELS];
  logic [WIDTH-1:0] acc_rd_s;
  logic [WIDTH-1:0] base_s;
  logic [WIDTH-1:0] result_s;
  logic             ovf_s;
  logic             in_range_s;
  logic             accept_s;
  logic             write_s;

  assign in_ready = !out_valid || out_ready;
  assign accept_s = in_valid && in_ready;

  // Guarded accumulator read and next-value arithmetic; out-of-range channels read zero.
  always_comb begin
    acc_rd_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      acc_rd_s = acc_rd_s | ({WIDTH{in_ch == CH_W'(i)}} & acc_r[i]);
    end
    in_range_s            = ({1'b0, in_ch} < CH_LIMIT);
    write_s               = accept_s && in_range_s;
    base_s                = clr ? '0 : acc_rd_s;
    {ovf_s, result_s}     = add_offset(base_s, in_data);
  end

  // Accumulator bank: clear zeroes every channel, an accepted write wins on its own channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (write_s && (in_ch == CH_W'(i))) begin
          acc_r[i] <= result_s;
        end else if (clr) begin
          acc_r[i] <= '0;
        end
      end
    end
  end

  // Output register: load on in-range accept, drop on retire, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else if (write_s) begin
      out_valid <= 1'b1;
      out_ch    <= in_ch;
      out_sum   <= result_s;
      out_ovf   <= ovf_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_param_offset_accumulator.sv
// Bench for param_offset_accumulator: directed scenarios plus randomized traffic against
// a transaction-level model, on a wrap/4-channel instance and a saturate/3-channel instance.
module tb_param_offset_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  always #5 clk = ~clk;

  logic       in_valid, in_ready, clr, out_valid, out_ready, out_ovf;
  logic [1:0] in_ch, out_ch;
  logic [7:0] in_data, out_sum;

  logic       s_in_valid, s_in_ready, s_clr, s_out_valid, s_out_ready, s_out_ovf;
  logic [1:0] s_in_ch, s_out_ch;
  logic [7:0] s_in_data, s_out_sum;

  int checks   = 0;
  int failures = 0;

  param_offset_accumulator #(.WIDTH(8), .OFFSET(2), .CHANNELS(4), .SATURATE(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
    .in_data(in_data), .clr(clr), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .out_sum(out_sum), .out_ovf(out_ovf));

  param_offset_accumulator #(.WIDTH(8), .OFFSET(2), .CHANNELS(3), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_ch(s_in_ch),
    .in_data(s_in_data), .clr(s_clr), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_ch(s_out_ch), .out_sum(s_out_sum), .out_ovf(s_out_ovf));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] ch, input logic [7:0] d,
                       input logic c, input logic ordy);
    in_valid = v; in_ch = ch; in_data = d; clr = c; out_ready = ordy;
  endtask

  task automatic drive_sat(input logic v, input logic [1:0] ch, input logic [7:0] d,
                           input logic c, input logic ordy);
    s_in_valid = v; s_in_ch = ch; s_in_data = d; s_clr = c; s_out_ready = ordy;
  endtask

  // Reference arithmetic straight from the rules: integer sum, overflow past 255.
  function automatic void ref_sum(input int a, input int d, input bit sat,
                                  output int r, output bit o);
    int s;
    s = a + d + 2;
    o = (s >= 256);
    r = (sat && o) ? 255 : (s % 256);
  endfunction

  task automatic do_reset();
    drive(1'b0, 2'd0, 8'd0, 1'b0, 1'b1);
    drive_sat(1'b0, 2'd0, 8'd0, 1'b0, 1'b1);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({out_valid, out_ch, out_sum, out_ovf, in_ready} !== {1'b0, 2'd0, 8'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset: v=%0b ch=%0d sum=%0d ovf=%0b rdy=%0b, want 0 0 0 0 1",
               out_valid, out_ch, out_sum, out_ovf, in_ready);
    end
    checks++;
    if ({s_out_valid, s_out_sum, s_in_ready} !== {1'b0, 8'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset_sat: v=%0b sum=%0d rdy=%0b", s_out_valid, s_out_sum, s_in_ready);
    end
  endtask

  task automatic test_basic();
    drive(1'b1, 2'd0, 8'd1, 1'b0, 1'b1);
    tick();
    drive(1'b0, 2'd0, 8'd0, 1'b0, 1'b1);
    checks++;
    if ({out_valid, out_ch, out_sum, out_ovf} !== {1'b1, 2'd0, 8'd3, 1'b0}) begin
      failures++;
      $display("FAIL basic: v=%0b ch=%0d sum=%0d ovf=%0b, want 1 0 3 0",
               out_valid, out_ch, out_sum, out_ovf);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL retire: out_valid=%0b, want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 2'd1, 8'd10, 1'b0, 1'b1);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_rdy0: in_ready=%0b, want 1", in_ready); end
    tick();
    drive(1'b1, 2'd1, 8'd20, 1'b0, 1'b1);
    #1;
    checks++;
    if (out_sum !== 8'd12 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first: sum=%0d rdy=%0b, want 12 1", out_sum, in_ready);
    end
    tick();
    drive(1'b0, 2'd0, 8'd0, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_sum !== 8'd34) begin
      failures++;
      $display("FAIL b2b_second: v=%0b ch=%0d sum=%0d, want 1 1 34", out_valid, out_ch, out_sum);
    end
    tick();
  endtask

  task automatic test_backpressure();
    drive(1'b1, 2'd2, 8'd4, 1'b0, 1'b0);
    tick();
    drive(1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 8'd6 || out_ch !== 2'd2) begin
        failures++;
        $display("FAIL bp_hold[%0d]: rdy=%0b v=%0b ch=%0d sum=%0d, want 0 1 2 6",
                 i, in_ready, out_valid, out_ch, out_sum);
      end
      tick();
    end
    drive(1'b1, 2'd2, 8'd4, 1'b0, 1'b0);
    tick();
    checks++;
    if (out_sum !== 8'd6) begin failures++; $display("FAIL bp_pending: sum=%0d, want 6", out_sum); end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release: in_ready=%0b, want 1", in_ready); end
    tick();
    drive(1'b0, 2'd0, 8'd0, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 8'd12) begin
      failures++;
      $display("FAIL bp_next: v=%0b sum=%0d, want 1 12", out_valid, out_sum);
    end
    tick();
  endtask

  task automatic test_overflow();
    logic [7:0] want_w [2];
    logic [7:0] want_s [3];
    logic       want_o [3];
    want_w[0] = 8'd252; want_w[1] = 8'd248;
    want_s[0] = 8'd252; want_s[1] = 8'd255; want_s[2] = 8'd255;
    want_o[0] = 1'b0;   want_o[1] = 1'b1;   want_o[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(i < 2, 2'd3, 8'd250, 1'b0, 1'b1);
      drive_sat(1'b1, 2'd2, (i < 2) ? 8'd250 : 8'd0, 1'b0, 1'b1);
      tick();
      if (i < 2) begin
        checks++;
        if (out_sum !== want_w[i] || out_ovf !== want_o[i] || out_ch !== 2'd3) begin
          failures++;
          $display("FAIL ovf_wrap[%0d]: ch=%0d sum=%0d ovf=%0b, want 3 %0d %0b",
                   i, out_ch, out_sum, out_ovf, want_w[i], want_o[i]);
        end
      end
      checks++;
      if (s_out_sum !== want_s[i] || s_out_ovf !== want_o[i] || s_out_valid !== 1'b1) begin
        failures++;
        $display("FAIL ovf_sat[%0d]: v=%0b sum=%0d ovf=%0b, want 1 %0d %0b",
                 i, s_out_valid, s_out_sum, s_out_ovf, want_s[i], want_o[i]);
      end
    end
    drive(1'b0, 2'd0, 8'd0, 1'b0, 1'b1);
    drive_sat(1'b0, 2'd0, 8'd0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_clr();
    drive(1'b0, 2'd0, 8'd0, 1'b1, 1'b1);
    tick();
    drive(1'b1, 2'd3, 8'd98, 1'b0, 1'b1);
    tick();
    checks++;
    if (out_sum !== 8'd100) begin failures++; $display("FAIL clr_pre: sum=%0d, want 100", out_sum); end
    drive(1'b1, 2'd3, 8'd5, 1'b1, 1'b1);
    tick();
    checks++;
    if (out_sum !== 8'd7 || out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL clr_accept: sum=%0d ovf=%0b, want 7 0", out_sum, out_ovf);
    end
    drive(1'b1, 2'd0, 8'd0, 1'b0, 1'b1);
    tick();
    checks++;
    if (out_sum !== 8'd2 || out_ch !== 2'd0) begin
      failures++;
      $display("FAIL clr_other: ch=%0d sum=%0d, want 0 2", out_ch, out_sum);
    end
    drive(1'b0, 2'd0, 8'd0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_out_of_range();
    drive_sat(1'b1, 2'd0, 8'd5, 1'b0, 1'b0);
    tick();
    drive_sat(1'b1, 2'd3, 8'd9, 1'b0, 1'b1);
    #1;
    checks++;
    if (s_in_ready !== 1'b1 || s_out_sum !== 8'd7) begin
      failures++;
      $display("FAIL oor_pre: rdy=%0b sum=%0d, want 1 7", s_in_ready, s_out_sum);
    end
    tick();
    checks++;
    if (s_out_valid !== 1'b0) begin failures++; $display("FAIL oor_drop: out_valid=%0b, want 0", s_out_valid); end
    drive_sat(1'b1, 2'd0, 8'd0, 1'b0, 1'b1);
    tick();
    checks++;
    if (s_out_sum !== 8'd9 || s_out_ch !== 2'd0) begin
      failures++;
      $display("FAIL oor_ch0: ch=%0d sum=%0d, want 0 9", s_out_ch, s_out_sum);
    end
    drive_sat(1'b0, 2'd0, 8'd0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_async_reset();
    drive(1'b1, 2'd1, 8'd1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
    #2;
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL arst_pre: out_valid=%0b, want 1", out_valid); end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_sum !== 8'd0) begin
      failures++;
      $display("FAIL arst_async: v=%0b sum=%0d, want 0 0", out_valid, out_sum);
    end
    tick();
    rst = 1'b0;
    drive(1'b1, 2'd1, 8'd0, 1'b0, 1'b1);
    drive_sat(1'b0, 2'd0, 8'd0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 2'd0, 8'd0, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 8'd2) begin
      failures++;
      $display("FAIL arst_zeroed: v=%0b sum=%0d, want 1 2", out_valid, out_sum);
    end
    tick();
  endtask

  task automatic test_random();
    int  m_acc [4];
    int  s_acc [3];
    bit  m_v, s_v, m_o, s_o, m_acc_ok, s_acc_ok, bit_o;
    int  m_sum, s_sum, m_ch, s_ch, r;
    logic [1:0] ch, sch;
    logic [7:0] d, sd;
    logic v, sv, c, sc, ordy, sordy;
    do_reset();
    m_acc = '{default: 0}; s_acc = '{default: 0};
    m_v = 1'b0; s_v = 1'b0; m_sum = 0; s_sum = 0; m_ch = 0; s_ch = 0; m_o = 1'b0; s_o = 1'b0;
    for (int n = 0; n < 400; n++) begin
      v = 1'($urandom_range(0, 3) != 0); ch = 2'($urandom_range(0, 3));
      d = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 255));
      c = 1'($urandom_range(0, 15) == 0); ordy = 1'($urandom_range(0, 3) != 0);
      sv = 1'($urandom_range(0, 3) != 0); sch = 2'($urandom_range(0, 3));
      sd = 8'($urandom_range(0, 255)); sc = 1'($urandom_range(0, 15) == 0);
      sordy = 1'($urandom_range(0, 3) != 0);
      drive(v, ch, d, c, ordy);
      drive_sat(sv, sch, sd, sc, sordy);
      #1;
      checks++;
      if (in_ready !== (!m_v || ordy) || s_in_ready !== (!s_v || sordy)) begin
        failures++;
        $display("FAIL rnd_ready[%0d]: rdy=%0b/%0b, want %0b/%0b", n, in_ready, s_in_ready,
                 !m_v || ordy, !s_v || sordy);
      end
      // Model update for the wrap instance: clear first, then apply the accepted addend.
      m_acc_ok = v && (!m_v || ordy);
      if (c) m_acc = '{default: 0};
      if (m_acc_ok) begin
        ref_sum(m_acc[ch], int'(d), 1'b0, r, bit_o);
        m_acc[ch] = r; m_v = 1'b1; m_sum = r; m_ch = int'(ch); m_o = bit_o;
      end else if (ordy) begin
        m_v = 1'b0;
      end
      s_acc_ok = sv && (!s_v || sordy);
      if (sc) s_acc = '{default: 0};
      if (s_acc_ok && sch < 2'd3) begin
        ref_sum(s_acc[sch], int'(sd), 1'b1, r, bit_o);
        s_acc[sch] = r; s_v = 1'b1; s_sum = r; s_ch = int'(sch); s_o = bit_o;
      end else if (sordy) begin
        s_v = 1'b0;
      end
      tick();
      checks++;
      if (out_valid !== m_v || (m_v && (out_sum !== 8'(m_sum) || out_ch !== 2'(m_ch) || out_ovf !== m_o))) begin
        failures++;
        $display("FAIL rnd_wrap[%0d]: v=%0b ch=%0d sum=%0d ovf=%0b, want %0b %0d %0d %0b",
                 n, out_valid, out_ch, out_sum, out_ovf, m_v, m_ch, m_sum, m_o);
      end
      checks++;
      if (s_out_valid !== s_v || (s_v && (s_out_sum !== 8'(s_sum) || s_out_ch !== 2'(s_ch) || s_out_ovf !== s_o))) begin
        failures++;
        $display("FAIL rnd_sat[%0d]: v=%0b ch=%0d sum=%0d ovf=%0b, want %0b %0d %0d %0b",
                 n, s_out_valid, s_out_ch, s_out_sum, s_out_ovf, s_v, s_ch, s_sum, s_o);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_clr();
    test_out_of_range();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
